// File: rtl/expr_pkg.sv
// Shared opcode encoding and lane-slicing helpers for the expression evaluator.
package expr_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XNOR = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } op_e;

  // Lane 0 sits in the most significant slice of every packed bus.
  function automatic int lane_lsb(input int lane, input int lanes, input int width);
    return (lanes - 1 - lane) * width;
  endfunction

  function automatic int lane_bit(input int lane, input int lanes);
    return lanes - 1 - lane;
  endfunction

endpackage

// File: rtl/expr_lane.sv
// One combinational evaluation lane: arithmetic, logic and shift ops with
// signed/unsigned overflow detection.
module expr_lane
  import expr_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  input  logic            sgn,
  output logic [W-1:0]    y,
  output logic            ovf
);

  logic [2*W-1:0]        ae;
  logic [2*W-1:0]        be;
  logic [2*W-1:0]        sum;
  logic [2*W-1:0]        diff;
  logic [2*W-1:0]        prod;
  logic [2*W-1:0]        wide;
  logic                  arith;
  logic [4:0]            amt;
  logic signed [W-1:0]   sra;

  // Double-width extension makes the true result of add/sub/mul exact, so
  // overflow is simply "upper half is not the extension of the low half".
  assign ae   = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
  assign be   = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
  assign sum  = ae + be;
  assign diff = ae - be;
  assign prod = ae * be;

  generate
    if (W >= 5) begin : g_amt_wide
      assign amt = b[4:0];
    end else begin : g_amt_narrow
      assign amt = {{(5 - W){1'b0}}, b};
    end
  endgenerate

  // Arithmetic shift past the width fills with the sign bit.
  assign sra = $signed(a) >>> amt;

  always_comb begin
    y     = '0;
    ovf   = 1'b0;
    wide  = '0;
    arith = 1'b0;
    case (op_e'(op))
      OP_ADD:  begin wide = sum;  arith = 1'b1; end
      OP_SUB:  begin wide = diff; arith = 1'b1; end
      OP_MUL:  begin wide = prod; arith = 1'b1; end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XNOR: y = ~(a ^ b);
      OP_SHL:  y = a << amt;
      OP_SHR:  y = sgn ? sra : (a >> amt);
      default: y = '0;
    endcase
    if (arith) begin
      y   = wide[W-1:0];
      ovf = (wide[2*W-1:W] != (sgn ? {W{wide[W-1]}} : {W{1'b0}}));
    end
  end

endmodule

// File: rtl/expr_pipe_eval.sv
// Two-stage valid/ready pipeline evaluating LANES independent expressions:
// S1 registers operands, S2 registers lane results.
module expr_pipe_eval
  import expr_pkg::*;
#(
  parameter int W     = 6,
  parameter int LANES = 6,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*W-1:0]    a,
  input  logic [LANES*W-1:0]    b,
  input  logic [LANES*OP_W-1:0] op,
  input  logic [LANES-1:0]      sgn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*W-1:0]    y,
  output logic [LANES-1:0]      ovf,
  output logic [CNT_W-1:0]      txn_cnt
);

  logic                  s1_valid_reg;
  logic [LANES*W-1:0]    s1_a_reg;
  logic [LANES*W-1:0]    s1_b_reg;
  logic [LANES*OP_W-1:0] s1_op_reg;
  logic [LANES-1:0]      s1_sgn_reg;
  logic                  s2_valid_reg;
  logic [LANES*W-1:0]    y_reg;
  logic [LANES*W-1:0]    y_next;
  logic [LANES-1:0]      ovf_reg;
  logic [LANES-1:0]      ovf_next;
  logic [CNT_W-1:0]      txn_cnt_reg;
  logic                  s1_adv;
  logic                  out_fire;

  assign s1_adv    = !s2_valid_reg || out_ready;
  // Gated by rst_n so the block never claims readiness while held in reset.
  assign in_ready  = rst_n && (!s1_valid_reg || s1_adv);
  assign out_fire  = s2_valid_reg && out_ready;
  assign out_valid = s2_valid_reg;
  assign y         = y_reg;
  assign ovf       = ovf_reg;
  assign txn_cnt   = txn_cnt_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int DLSB = lane_lsb(gi, LANES, W);
      localparam int OLSB = lane_lsb(gi, LANES, OP_W);
      localparam int BIT  = lane_bit(gi, LANES);
      expr_lane #(.W(W)) u_lane (
        .a   (s1_a_reg[DLSB +: W]),
        .b   (s1_b_reg[DLSB +: W]),
        .op  (s1_op_reg[OLSB +: OP_W]),
        .sgn (s1_sgn_reg[BIT]),
        .y   (y_next[DLSB +: W]),
        .ovf (ovf_next[BIT])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= '0;
      s1_sgn_reg   <= '0;
      s2_valid_reg <= 1'b0;
      y_reg        <= '0;
      ovf_reg      <= '0;
      txn_cnt_reg  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_a_reg   <= a;
          s1_b_reg   <= b;
          s1_op_reg  <= op;
          s1_sgn_reg <= sgn;
        end
      end
      // Results only load from a valid S1 so a bubble leaves y untouched.
      if (s1_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          y_reg   <= y_next;
          ovf_reg <= ovf_next;
        end
      end
      if (out_fire) begin
        txn_cnt_reg <= txn_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule
